// File: rtl/uart_tx_core.sv
// uart_tx_core: buffered 8-N-1 serial transmitter with txi/tbnf status bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrien,
    input  logic [7:0] idata,
    output logic       txd,
    output logic       txi,
    output logic       tbnf
);
    localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [15:0]   BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          txi_q, txi_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head;
    logic          push, pop, baud_end;

    assign head     = mem[rd_ptr_q];
    assign baud_end = (baud_q == BAUD_LAST);
    // A full buffer still takes a write when the FSM pops on the same edge.
    assign push     = wrien && ((count_q < FULL_COUNT) || pop);

    assign txd  = txd_q;
    assign txi  = txi_q;
    assign tbnf = (count_q < FULL_COUNT);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                if (count_q != '0) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    txd_d    = 1'b0;
                    state_d  = START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            START: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d  = '0;
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (count_q != '0) begin
                        pop      = 1'b1;
                        shift_d  = head;
                        txd_d    = 1'b0;
                        state_d  = START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A write never makes txi fall on its own edge; only leaving IDLE does.
    assign txi_d = (state_d == IDLE) && (count_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            txi_q    <= 1'b1;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            txi_q    <= txi_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr_q] <= idata;
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: directed writes feed an expected-byte queue; a line
// monitor decodes frames from txd and checks them against that queue.
module tb_uart_tx_core;
    localparam int CPB = 4;
    localparam int DEP = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wrien = 1'b0;
    logic [7:0] idata = 8'h00;
    logic       txd, txi, tbnf;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         frame_starts[$];

    uart_tx_core #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
        .clk   (clk),
        .rst   (rst),
        .wrien (wrien),
        .idata (idata),
        .txd   (txd),
        .txi   (txi),
        .tbnf  (tbnf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called on a negedge; the write lands on the following posedge.
    task automatic write_byte(input logic [7:0] b, input bit accept);
        wrien = 1'b1;
        idata = b;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        wrien = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (txi !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(txi), 32'd1);
    endtask

    task automatic time_frame(input logic [7:0] b, input string tag);
        int lowcnt;
        write_byte(b, 1'b1);
        check({tag, "_txd_before"}, 32'(txd), 32'd1);
        check({tag, "_txi_before"}, 32'(txi), 32'd1);
        @(negedge clk);
        check({tag, "_txd_fall"}, 32'(txd), 32'd0);
        check({tag, "_txi_fall"}, 32'(txi), 32'd0);
        lowcnt = 1;
        while (lowcnt < 200) begin
            @(negedge clk);
            if (txi) break;
            lowcnt++;
        end
        check({tag, "_txi_low_cycles"}, 32'(lowcnt), 32'(FRAME_CYC));
    endtask

    // Line monitor: samples every cycle of a frame, requires each bit to be
    // steady for CPB cycles, then compares against the head of exp_q.
    initial begin : monitor
        logic [FRAME_BITS-1:0] bits;
        logic [7:0]            exp_b;
        logic                  steady, aborted, shape_ok;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                frame_starts.push_back(cyc);
                bits    = '0;
                steady  = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < FRAME_CYC; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % CPB == 0) bits[k / CPB] = txd;
                    else if (txd !== bits[k / CPB]) steady = 1'b0;
                end
                if (!aborted) begin
                    check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_b    = exp_q.pop_front();
                        shape_ok = steady && (bits[0] == 1'b0) && (bits[FRAME_BITS-1] == 1'b1);
`ifdef UART_TX_PARITY_EN
                        shape_ok = shape_ok && (bits[9] == ^exp_b);
`endif
                        check("frame_shape", 32'(shape_ok), 32'd1);
                        check("frame_byte", 32'(bits[8:1]), 32'(exp_b));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    logic [7:0] full_bytes [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    logic       full_tbnf  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin : stimulus
        int v, n0, target, zeros;

        // Power-on reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_txi", 32'(txi), 32'd1);
        check("reset_tbnf", 32'(tbnf), 32'd1);
        repeat (2) @(negedge clk);

        // Single frame 0xA5: bits 0,1,0,1,0,0,1,0,1,1
        time_frame(8'hA5, "a5");

        // Back-to-back frames with no idle gap
        n0 = frame_starts.size();
        write_byte(8'h00, 1'b1);
        v = cyc;
        write_byte(8'hFF, 1'b1);
        @(negedge clk);
        wait_idle("b2b");
        check("b2b_frames", 32'(frame_starts.size() - n0), 32'd2);
        if (frame_starts.size() >= n0 + 2) begin
            check("b2b_latency", 32'(frame_starts[n0] - v), 32'd1);
            check("b2b_gap", 32'(frame_starts[n0+1] - frame_starts[n0]), 32'(FRAME_CYC));
        end

        // Fill buffer during a frame; fifth byte dropped
        write_byte(8'h10, 1'b1);
        v = cyc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            write_byte(full_bytes[i], full_tbnf[i] | (i < 4));
            check($sformatf("full_tbnf_%0d", i), 32'(tbnf), 32'(full_tbnf[i]));
        end

        // Write on the STOP-end pop edge of the first frame
        target = v + FRAME_CYC;
        while (cyc < target) @(negedge clk);
        check("pushpop_tbnf_before", 32'(tbnf), 32'd0);
        write_byte(8'h16, 1'b1);
        check("pushpop_tbnf_after", 32'(tbnf), 32'd0);
        check("pushpop_next_start", 32'(txd), 32'd0);
        @(negedge clk);
        check("pushpop_tbnf_hold", 32'(tbnf), 32'd0);
        wait_idle("full");
        check("full_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame with a byte still buffered
        write_byte(8'h3C, 1'b1);
        write_byte(8'h5A, 1'b1);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_txi", 32'(txi), 32'd1);
        check("midrst_tbnf", 32'(tbnf), 32'd1);
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || txi !== 1'b1) zeros++;
        end
        check("midrst_line_quiet", 32'(zeros), 32'd0);

        // Traffic resumes normally after reset
        time_frame(8'h5C, "post_rst");

`ifdef UART_TX_PARITY_EN
        time_frame(8'h07, "par07");
        time_frame(8'hA5, "para5");
`endif

        repeat (5) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
